video_line_fetch: RTL
=====================

VIDEO_LINE_FETCH -- requirements
Module: video_line_fetch

Interface
REQ-001 SHALL have parameter LINE_WORDS, default 640, meaning 32-bit words fetched per scanline (1..1024).
REQ-002 SHALL have parameter VLINE, default 480, meaning active lines per frame (1..2047).
REQ-003 SHALL have port i_clock  in  1  single clock for all logic.
REQ-004 SHALL have port i_reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port i_enable  in  1  fetch enable, sampled only at frame start.
REQ-006 SHALL have port i_base  in  32  framebuffer byte base address, sampled at frame start.
REQ-007 SHALL have ports i_hblank, i_vblank  in  1 each  timing-generator blanking flags (1 = blanking), synchronous to i_clock.
REQ-008 SHALL have ports o_bus_request  out  1, o_bus_address  out  32, i_bus_ready  in  1, i_bus_rdata  in  32  (read-request bus).
REQ-009 SHALL have ports o_lb_write  out  1, o_lb_bank  out  1, o_lb_index  out  10, o_lb_data  out  32  (line-buffer write port).
REQ-010 SHALL have ports o_display_bank  out  1, o_underrun  out  1, o_busy  out  1.

Function
REQ-011 SHALL register i_hblank/i_vblank once for edge detect; frame start = vblank 0->1, line end = hblank 0->1 while i_vblank=0.
REQ-012 SHALL implement states IDLE, PREFETCH, WAIT_LINE, FETCH.
REQ-013 At frame start: latch i_base into frame_base; latch i_enable; line counter = 0; o_display_bank = 0; if enabled go PREFETCH (fetch line 0 into bank 0), else IDLE.
REQ-014 PREFETCH/FETCH SHALL assert o_bus_request with o_bus_address = frame_base + line*LINE_WORDS*4 + index*4 (32-bit wrap), index counting 0..LINE_WORDS-1.
REQ-015 Handshake: word accepted in any cycle with o_bus_request=1 and i_bus_ready=1; address held stable until accepted; next address may be presented the following cycle (back-to-back allowed).
REQ-016 The cycle after an accept SHALL pulse o_lb_write=1 for one cycle with o_lb_data = i_bus_rdata captured at accept, o_lb_index = accepted index, o_lb_bank = target bank.
REQ-017 After the accept of index LINE_WORDS-1: o_bus_request drops next cycle, line counter increments, state -> WAIT_LINE.
REQ-018 In WAIT_LINE, on line end: o_display_bank toggles; if line counter < VLINE, state -> FETCH into bank = new ~o_display_bank; else remain WAIT_LINE without requests.
REQ-019 Line end while in PREFETCH or FETCH SHALL: pulse o_underrun for one cycle, abort the current line (no further lb writes for it, request dropped next cycle unless accepted that cycle), toggle o_display_bank, and restart FETCH at index 0 for line counter+1 if < VLINE, else WAIT_LINE.
REQ-020 An accept occurring in the same cycle as an aborting line end SHALL still produce its o_lb_write to the old bank.
REQ-021 Frame start SHALL take priority over any state, aborting any fetch without o_underrun.
REQ-022 o_busy SHALL equal 1 in PREFETCH or FETCH, else 0.
REQ-023 While IDLE: no requests, no lb writes, o_display_bank constant.

Reset
REQ-024 On i_reset=1 asynchronously: state IDLE; o_bus_request, o_lb_write, o_underrun, o_busy, o_display_bank = 0; o_bus_address, o_lb_index, o_lb_data, o_lb_bank = 0; counters 0; edge registers = 1 (no spurious edge after release).
REQ-025 Reset asserted mid-fetch SHALL drop o_bus_request immediately; no further activity until next frame start with i_enable=1.

Verification
REQ-026 LINE_WORDS=4, i_base=0x1000, i_bus_ready=1 constant, frame start -> addresses 0x1000,0x1004,0x1008,0x100C on consecutive cycles; lb writes bank 0 indices 0..3 one cycle later; state WAIT_LINE.
REQ-027 Same, first line end -> o_display_bank=1, fetch addresses 0x1010..0x101C into bank 0 (line 1), no o_underrun.
REQ-028 i_bus_ready toggled 1,0,1,0 -> address held while ready=0; exactly LINE_WORDS lb writes, indices strictly sequential.
REQ-029 i_bus_ready=0 held, line end during PREFETCH -> one-cycle o_underrun, o_display_bank=1, fetch restarts at line 1 address 0x1010 index 0.
REQ-030 VLINE=2 -> after second fetched line, further line ends toggle bank but issue no requests until next frame start; i_enable=0 at frame start -> IDLE, no requests.
REQ-031 i_reset pulsed while o_bus_request=1 -> all outputs 0 same cycle; vblank held 1 across release produces no frame start.

Source files
------------

// File: rtl/video_line_fetch_if.sv
// Timing, read-request bus and line-buffer write signals of the scanline fetcher.
// master = fetcher side, slave = timing generator / memory / line buffer side.
interface video_line_fetch_if;
  logic        i_enable;
  logic [31:0] i_base;
  logic        i_hblank;
  logic        i_vblank;
  logic        o_bus_request;
  logic [31:0] o_bus_address;
  logic        i_bus_ready;
  logic [31:0] i_bus_rdata;
  logic        o_lb_write;
  logic        o_lb_bank;
  logic [9:0]  o_lb_index;
  logic [31:0] o_lb_data;
  logic        o_display_bank;
  logic        o_underrun;
  logic        o_busy;

  modport master (
    input  i_enable, i_base, i_hblank, i_vblank, i_bus_ready, i_bus_rdata,
    output o_bus_request, o_bus_address, o_lb_write, o_lb_bank, o_lb_index,
           o_lb_data, o_display_bank, o_underrun, o_busy
  );

  modport slave (
    output i_enable, i_base, i_hblank, i_vblank, i_bus_ready, i_bus_rdata,
    input  o_bus_request, o_bus_address, o_lb_write, o_lb_bank, o_lb_index,
           o_lb_data, o_display_bank, o_underrun, o_busy
  );
endinterface

// File: rtl/video_line_fetch.sv
// Scanline prefetcher: reads LINE_WORDS words per line into a double-buffered line
// buffer one line ahead of display; all outputs registered, writes land one cycle after accept.
module video_line_fetch #(
  parameter int LINE_WORDS = 640,
  parameter int VLINE      = 480
) (
  input logic                i_clock,
  input logic                i_reset,
  video_line_fetch_if.master bus
);

  typedef enum logic [1:0] {IDLE, PREFETCH, WAIT_LINE, FETCH} state_t;

  state_t      state_q, state_d;
  logic        hb_q, hb_d;
  logic        vb_q, vb_d;
  logic [31:0] frame_base_q, frame_base_d;
  logic [11:0] line_q, line_d;
  logic [9:0]  idx_q, idx_d;
  logic        bank_q, bank_d;
  logic        disp_q, disp_d;
  logic        req_q, req_d;
  logic [31:0] addr_q, addr_d;
  logic        lb_write_q, lb_write_d;
  logic        lb_bank_q, lb_bank_d;
  logic [9:0]  lb_index_q, lb_index_d;
  logic [31:0] lb_data_q, lb_data_d;
  logic        underrun_q, underrun_d;
  logic        busy_q, busy_d;

  logic        frame_start;
  logic        line_end;
  logic        accept;
  logic [11:0] line_inc;

  assign frame_start = bus.i_vblank & ~vb_q;
  assign line_end    = bus.i_hblank & ~hb_q & ~bus.i_vblank;
  assign accept      = req_q & bus.i_bus_ready;
  assign line_inc    = line_q + 12'd1;

  function automatic logic [31:0] word_addr(input logic [31:0] base,
                                            input logic [11:0] line,
                                            input logic [9:0]  idx);
    logic [31:0] off;
    off = 32'(line) * 32'(LINE_WORDS) + 32'(idx);
    return base + (off << 2);
  endfunction

  always_comb begin
    state_d      = state_q;
    hb_d         = bus.i_hblank;
    vb_d         = bus.i_vblank;
    frame_base_d = frame_base_q;
    line_d       = line_q;
    idx_d        = idx_q;
    bank_d       = bank_q;
    disp_d       = disp_q;
    req_d        = req_q;
    addr_d       = addr_q;
    lb_write_d   = 1'b0;
    lb_bank_d    = lb_bank_q;
    lb_index_d   = lb_index_q;
    lb_data_d    = lb_data_q;
    underrun_d   = 1'b0;

    // A transferred word is always written, even if the line is aborted this cycle.
    if (accept) begin
      lb_write_d = 1'b1;
      lb_bank_d  = bank_q;
      lb_index_d = idx_q;
      lb_data_d  = bus.i_bus_rdata;
    end

    if (frame_start) begin
      frame_base_d = bus.i_base;
      line_d       = 12'd0;
      idx_d        = 10'd0;
      bank_d       = 1'b0;
      disp_d       = 1'b0;
      addr_d       = bus.i_base;
      req_d        = bus.i_enable;
      state_d      = bus.i_enable ? PREFETCH : IDLE;
    end else begin
      case (state_q)
        PREFETCH, FETCH: begin
          if (line_end) begin
            underrun_d = 1'b1;
            disp_d     = ~disp_q;
            line_d     = line_inc;
            idx_d      = 10'd0;
            if (line_inc < 12'(VLINE)) begin
              state_d = FETCH;
              bank_d  = disp_q;
              req_d   = 1'b1;
              addr_d  = word_addr(frame_base_q, line_inc, 10'd0);
            end else begin
              state_d = WAIT_LINE;
              req_d   = 1'b0;
            end
          end else if (accept) begin
            if (idx_q == 10'(LINE_WORDS - 1)) begin
              state_d = WAIT_LINE;
              req_d   = 1'b0;
              line_d  = line_inc;
              idx_d   = 10'd0;
            end else begin
              idx_d  = idx_q + 10'd1;
              addr_d = word_addr(frame_base_q, line_q, idx_q + 10'd1);
            end
          end
        end
        WAIT_LINE: begin
          if (line_end) begin
            disp_d = ~disp_q;
            // The freshly displayed bank is ~disp_q, so fill the one just released.
            if (line_q < 12'(VLINE)) begin
              state_d = FETCH;
              bank_d  = disp_q;
              idx_d   = 10'd0;
              req_d   = 1'b1;
              addr_d  = word_addr(frame_base_q, line_q, 10'd0);
            end
          end
        end
        default: begin
        end
      endcase
    end

    busy_d = (state_d == PREFETCH) || (state_d == FETCH);
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q      <= IDLE;
      hb_q         <= 1'b1;
      vb_q         <= 1'b1;
      frame_base_q <= 32'd0;
      line_q       <= 12'd0;
      idx_q        <= 10'd0;
      bank_q       <= 1'b0;
      disp_q       <= 1'b0;
      req_q        <= 1'b0;
      addr_q       <= 32'd0;
      lb_write_q   <= 1'b0;
      lb_bank_q    <= 1'b0;
      lb_index_q   <= 10'd0;
      lb_data_q    <= 32'd0;
      underrun_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      hb_q         <= hb_d;
      vb_q         <= vb_d;
      frame_base_q <= frame_base_d;
      line_q       <= line_d;
      idx_q        <= idx_d;
      bank_q       <= bank_d;
      disp_q       <= disp_d;
      req_q        <= req_d;
      addr_q       <= addr_d;
      lb_write_q   <= lb_write_d;
      lb_bank_q    <= lb_bank_d;
      lb_index_q   <= lb_index_d;
      lb_data_q    <= lb_data_d;
      underrun_q   <= underrun_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.o_bus_request  = req_q;
  assign bus.o_bus_address  = addr_q;
  assign bus.o_lb_write     = lb_write_q;
  assign bus.o_lb_bank      = lb_bank_q;
  assign bus.o_lb_index     = lb_index_q;
  assign bus.o_lb_data      = lb_data_q;
  assign bus.o_display_bank = disp_q;
  assign bus.o_underrun     = underrun_q;
  assign bus.o_busy         = busy_q;

endmodule
